// File: rtl/sync_fifo_prog_if.sv
// Handshake bundle for sync_fifo_prog: write/read requests, read data and
// every status output. The FIFO sits on the slave side and the producer/consumer
// logic sits on the master side.
interface sync_fifo_prog_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] iv_din;
  logic                  i_wr;
  logic                  i_rd;
  logic [FIFO_WIDTH-1:0] ov_dout;
  logic                  o_valid;
  logic                  o_full;
  logic                  o_half_full;
  logic                  o_prog_full;
  logic                  o_empty;
  logic                  o_prog_empty;
  logic [AW:0]           ov_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output iv_din, i_wr, i_rd,
    input  ov_dout, o_valid, o_full, o_half_full, o_prog_full,
           o_empty, o_prog_empty, ov_count, o_overflow, o_underflow
  );

  modport slave (
    input  iv_din, i_wr, i_rd,
    output ov_dout, o_valid, o_full, o_half_full, o_prog_full,
           o_empty, o_prog_empty, ov_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO on distributed memory with programmable full/empty
// thresholds, live occupancy, one-cycle overflow/underflow pulses and a
// compile-time choice of standard or first-word-fall-through reads.
// All status flags are decoded from the registered count only.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH        = 8,
  parameter int FIFO_DEPTH        = 16,
  parameter int FWFT              = 0,
  parameter int PROG_FULL_THRESH  = 12,
  parameter int PROG_EMPTY_THRESH = 2
) (
  input  logic               clk,
  input  logic               reset,
  sync_fifo_prog_if.slave    fifo
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   HALF_C   = (AW+1)'(FIFO_DEPTH / 2);
  localparam logic [AW:0]   PFULL_C  = (AW+1)'(PROG_FULL_THRESH);
  localparam logic [AW:0]   PEMPTY_C = (AW+1)'(PROG_EMPTY_THRESH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  overflow;
  logic                  underflow;

  // Acceptance depends only on registered occupancy, so a read cannot free
  // space for a write in the same cycle (and vice versa).
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign wr_acc = fifo.i_wr && !full;
  assign rd_acc = fifo.i_rd && !empty;

  // Storage write; contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= fifo.iv_din;
    end
  end

  // Pointers, occupancy and rejected-request pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      overflow  <= fifo.i_wr && full;
      underflow <= fifo.i_rd && empty;
    end
  end

  assign fifo.o_full       = full;
  assign fifo.o_empty      = empty;
  assign fifo.o_half_full  = (count >= HALF_C);
  assign fifo.o_prog_full  = (count >= PFULL_C);
  assign fifo.o_prog_empty = (count <= PEMPTY_C);
  assign fifo.ov_count     = count;
  assign fifo.o_overflow   = overflow;
  assign fifo.o_underflow  = underflow;

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; a read acknowledges and advances it.
      assign fifo.ov_dout = mem[rd_ptr];
      assign fifo.o_valid = !empty;
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_p1;
      logic                  vld_p1;

      // Read stage: data and valid land one cycle after the accepted read.
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) begin
            dout_p1 <= mem[rd_ptr];
          end
        end
      end

      assign fifo.ov_dout = dout_p1;
      assign fifo.o_valid = vld_p1;
    end
  endgenerate
endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised single-clock distributed-RAM FIFO: the next generation of our sync FIFO. Beyond full, half-full and empty, it adds programmable full and empty thresholds, a live occupancy count, sticky-free overflow and underflow error pulses, and a compile-time choice between standard read latency and first-word-fall-through (FWFT). It is used as the general buffering element between pixel/packet pipeline stages in one clock domain.

## Interface
- FIFO_WIDTH, 8: data width in bits, 1 or more.
- FIFO_DEPTH, 16: number of words; a power of two, 4 or more.
- FWFT, 0: read mode. 0 = standard (data one cycle after the read). 1 = first-word-fall-through.
- PROG_FULL_THRESH, 12: `o_prog_full` is asserted when count ≥ this value. Legal range is 1..FIFO_DEPTH.
- PROG_EMPTY_THRESH, 2: `o_prog_empty` is asserted when count ≤ this value. Legal range is 0..FIFO_DEPTH-1.
- Let AW = log2(FIFO_DEPTH).

Ports:
- clk, in, 1: the only clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- iv_din, in, FIFO_WIDTH: write data.
- i_wr, in, 1: write request.
- i_rd, in, 1: read request (in FWFT mode, a pop/acknowledge).
- ov_dout, out, FIFO_WIDTH: read data.
- o_valid, out, 1: `ov_dout` holds a valid word.
- o_full, out, 1: count == FIFO_DEPTH.
- o_half_full, out, 1: count ≥ FIFO_DEPTH/2.
- o_prog_full, out, 1: count ≥ PROG_FULL_THRESH.
- o_empty, out, 1: count == 0.
- o_prog_empty, out, 1: count ≤ PROG_EMPTY_THRESH.
- ov_count, out, AW+1: number of words currently held.
- o_overflow, out, 1: one-cycle pulse flagging a rejected write.
- o_underflow, out, 1: one-cycle pulse flagging a rejected read.

## Operation
- **Storage:** FIFO_DEPTH × FIFO_WIDTH distributed/SRL-style memory. Write pointer and read pointer are each AW bits and wrap naturally from FIFO_DEPTH-1 to 0.
- **Accepted write:** i_wr && !o_full. The word at iv_din goes to mem[wr_ptr] and wr_ptr increments.
- **Accepted read:** i_rd && !o_empty. rd_ptr increments.
- **Rejected write:** i_wr while full. Memory, pointers and count are unchanged. o_overflow pulses for one cycle. This holds even if an accepted read occurs in the same cycle.
- **Rejected read:** i_rd while empty. Nothing changes. o_underflow pulses for one cycle. This holds even if a write occurs in the same cycle.
- **Count update:** count +1 on an accepted write alone, −1 on an accepted read alone, unchanged when both are accepted in the same cycle. Count never exceeds FIFO_DEPTH and never goes below 0.
- **Status flags:** all status flags are decoded from the registered count only. They are never derived from the current-cycle requests.
- **FWFT = 0:** on an accepted read, ov_dout is loaded with mem[rd_ptr] at that edge, and o_valid is high for exactly the following cycle. Otherwise ov_dout holds its last value and o_valid is 0.
- **FWFT = 1:** ov_dout = mem[rd_ptr] combinationally, and o_valid = !o_empty. The head word is visible while not empty, and i_rd consumes it. The count includes the displayed word.
- **Reset:** discards all content. Pointers, count, ov_dout, o_valid, o_full, o_half_full, o_prog_full, o_overflow and o_underflow are all 0. o_empty = 1. o_prog_empty = 1. Memory contents are not cleared.

## Timing
- All outputs are registered or decoded from registers. The only exception is ov_dout in FWFT mode, which is a combinational read of registered pointers.
- **Write to not-empty:** a write accepted at edge N makes o_empty fall and ov_count increase after edge N. With FWFT = 1, the word appears on ov_dout in the cycle after edge N. Write-to-readable latency is 1 cycle.
- **Read latency, FWFT = 0:** a read accepted at edge N gives data and o_valid = 1 in the cycle after edge N.
- **Full to not-full:** a read accepted at edge N while full deasserts o_full after edge N. A write presented in the cycle after edge N is accepted.
- **Overflow/underflow pulses:** asserted in the cycle following the rejected request's edge. Consecutive rejections produce continuous assertion.
- **Reset timing:** reset sampled high at edge N forces reset values after edge N. Requests presented in the same cycle as reset are ignored and produce no error pulses.

## Test plan
- **Reset:** assert reset for 3 cycles with i_wr = 1 → count = 0, o_empty = 1, o_prog_empty = 1, o_overflow = 0, o_valid = 0.
- **Fill and drain (FWFT = 0, DEPTH = 16):**
  - Write 0x00..0x0F → o_half_full rises after the 8th write, o_prog_full after the 12th, o_full after the 16th.
  - 17th write (0xAA) → o_overflow pulses once and count stays 16.
  - Read 16 times → 0x00..0x0F in order, each with o_valid one cycle after the read.
- **Wrap-around:** write 10, read 10, write 16, read 16 → data order is preserved across the pointer wrap and count returns to 0.
- **Simultaneous operations:**
  - Read and write together at count = 5 → count stays 5.
  - Read and write together at count = 16 → write rejected with o_overflow, count 15.
  - Read and write together at count = 0 → read rejected with o_underflow, count 1.
- **FWFT = 1:** write 0x5A into an empty FIFO → in the cycle after the write, ov_dout = 0x5A and o_valid = 1 with no i_rd. Pop → o_empty = 1 and o_valid = 0 in the next cycle.
- **Reset mid-operation:** at count = 9, assert reset for 1 cycle → count 0, o_empty = 1. The next write of 0x33 followed by a read returns 0x33, not any stale word.
